// File: rtl/scpu_core.sv
// scpu_core: single-cycle 32-bit MIPS-subset CPU core.
//
// Every instruction is decoded and executed within one clock. The register
// file write-back and the PC update happen together on the rising edge.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous active-low reset (0 = reset asserted)
//   Data_in    read data from data memory/IO (lw)
//   inst_in    instruction word at address PC_out
//   MIO_ready  bus ready (reserved, ignored)
//   INT        interrupt request (reserved, ignored)
//   PC_out     current PC, byte address
//   Addr_out   ALU result; memory address for lw/sw
//   Data_out   rt read value; store data for sw
//   mem_w      high only while the current instruction is sw
//   CPU_MIO    high while the current instruction is lw or sw
module scpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Data_in,
    input  logic [31:0] inst_in,
    input  logic        MIO_ready,
    input  logic        INT,
    output logic [31:0] PC_out,
    output logic [31:0] Addr_out,
    output logic [31:0] Data_out,
    output logic        mem_w,
    output logic        CPU_MIO
);

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_LUI
    } alu_op_e;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target26;

    assign opcode   = inst_in[31:26];
    assign rs       = inst_in[25:21];
    assign rt       = inst_in[20:16];
    assign rd       = inst_in[15:11];
    assign shamt    = inst_in[10:6];
    assign funct    = inst_in[5:0];
    assign imm16    = inst_in[15:0];
    assign target26 = inst_in[25:0];

    // Reserved inputs, deliberately not used by this core.
    logic unused_inputs;
    assign unused_inputs = MIO_ready ^ INT;

    // ------------------------------------------------------------------
    // Register file read ports ($0 hard-wired to zero)
    // ------------------------------------------------------------------
    logic [31:0] rs_val, rt_val;

    assign rs_val = (rs == 5'd0) ? '0 : regs_q[rs];
    assign rt_val = (rt == 5'd0) ? '0 : regs_q[rt];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    alu_op_e     alu_op;
    logic        src_imm;     // ALU operand B from immediate
    logic        imm_zext;    // zero-extend instead of sign-extend
    logic        reg_we;
    logic [4:0]  wr_addr;
    logic        wr_from_mem;
    logic        wr_link;     // jal: write PC+4
    logic        is_lw, is_sw, is_beq, is_bne, is_j, is_jr;

    always_comb begin
        alu_op      = ALU_ADD;
        src_imm     = 1'b0;
        imm_zext    = 1'b0;
        reg_we      = 1'b0;
        wr_addr     = rt;
        wr_from_mem = 1'b0;
        wr_link     = 1'b0;
        is_lw       = 1'b0;
        is_sw       = 1'b0;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        is_j        = 1'b0;
        is_jr       = 1'b0;

        unique case (opcode)
            OP_RTYPE: begin
                wr_addr = rd;
                reg_we  = 1'b1;
                unique case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_JR: begin
                        reg_we = 1'b0;
                        is_jr  = 1'b1;
                    end
                    default: reg_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_op  = ALU_ADD;
                src_imm = 1'b1;
                reg_we  = 1'b1;
            end
            OP_SLTI: begin
                alu_op  = ALU_SLT;
                src_imm = 1'b1;
                reg_we  = 1'b1;
            end
            OP_ANDI: begin
                alu_op   = ALU_AND;
                src_imm  = 1'b1;
                imm_zext = 1'b1;
                reg_we   = 1'b1;
            end
            OP_ORI: begin
                alu_op   = ALU_OR;
                src_imm  = 1'b1;
                imm_zext = 1'b1;
                reg_we   = 1'b1;
            end
            OP_XORI: begin
                alu_op   = ALU_XOR;
                src_imm  = 1'b1;
                imm_zext = 1'b1;
                reg_we   = 1'b1;
            end
            OP_LUI: begin
                alu_op  = ALU_LUI;
                src_imm = 1'b1;
                reg_we  = 1'b1;
            end
            OP_LW: begin
                src_imm     = 1'b1;
                reg_we      = 1'b1;
                wr_from_mem = 1'b1;
                is_lw       = 1'b1;
            end
            OP_SW: begin
                src_imm = 1'b1;
                is_sw   = 1'b1;
            end
            OP_BEQ: begin
                alu_op = ALU_SUB;
                is_beq = 1'b1;
            end
            OP_BNE: begin
                alu_op = ALU_SUB;
                is_bne = 1'b1;
            end
            OP_J: begin
                is_j = 1'b1;
            end
            OP_JAL: begin
                is_j    = 1'b1;
                reg_we  = 1'b1;
                wr_addr = 5'd31;
                wr_link = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] imm_ext, alu_a, alu_b, alu_res;

    assign imm_ext = imm_zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
    assign alu_a   = rs_val;
    assign alu_b   = src_imm ? imm_ext : rt_val;

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_XOR: alu_res = alu_a ^ alu_b;
            ALU_NOR: alu_res = ~(alu_a | alu_b);
            ALU_SLT: alu_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            // Shifts operate on rt, not on the rs/imm operand path.
            ALU_SLL: alu_res = rt_val << shamt;
            ALU_SRL: alu_res = rt_val >> shamt;
            ALU_LUI: alu_res = {imm16, 16'h0000};
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next PC
    // ------------------------------------------------------------------
    logic [31:0] pc_plus4, br_target, j_target;
    logic        rs_eq_rt, br_taken;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], target26, 2'b00};
    assign rs_eq_rt  = (rs_val == rt_val);
    assign br_taken  = (is_beq & rs_eq_rt) | (is_bne & ~rs_eq_rt);

    always_comb begin
        pc_d = pc_plus4;
        if (is_jr) begin
            pc_d = rs_val;
        end else if (is_j) begin
            pc_d = j_target;
        end else if (br_taken) begin
            pc_d = br_target;
        end
    end

    // ------------------------------------------------------------------
    // Write-back
    // ------------------------------------------------------------------
    logic [31:0] wr_data;

    always_comb begin
        wr_data = alu_res;
        if (wr_link) begin
            wr_data = pc_plus4;
        end else if (wr_from_mem) begin
            wr_data = Data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (reg_we && (wr_addr != 5'd0)) begin
                regs_q[wr_addr] <= wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign PC_out   = pc_q;
    assign Addr_out = alu_res;
    assign Data_out = rt_val;
    assign mem_w    = is_sw;
    assign CPU_MIO  = is_lw | is_sw;

endmodule

// File: tb/tb_scpu_core.sv
// Testbench for scpu_core: directed program from reset, randomized
// instruction stream, mid-program asynchronous reset. Expected outputs come
// from an instruction-level reference model and are checked by a monitor.
module tb_scpu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Data_in;
    logic [31:0] inst_in;
    logic        MIO_ready;
    logic        INT;
    logic [31:0] PC_out;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic        mem_w;
    logic        CPU_MIO;

    scpu_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .Data_in   (Data_in),
        .inst_in   (inst_in),
        .MIO_ready (MIO_ready),
        .INT       (INT),
        .PC_out    (PC_out),
        .Addr_out  (Addr_out),
        .Data_out  (Data_out),
        .mem_w     (mem_w),
        .CPU_MIO   (CPU_MIO)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        chk_addr;
        logic [31:0] dout;
        logic        memw;
        logic        mio;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_issued = 0;

    // Reference model: architectural state only.
    logic [31:0] mreg [32];
    logic [31:0] mpc;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s #%0d got=%h want=%h", nm, idx, act, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mpc = 32'h0;
    endtask

    // Executes one instruction on the model, returns the outputs the core
    // must present while that instruction is on inst_in.
    task automatic model_step(input logic [31:0] ins, input logic [31:0] din, output exp_t e);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, wa;
        logic [15:0] imm;
        logic [31:0] a, b, sx, zx, npc, wv;
        logic        wr;
        op = ins[31:26]; fn = ins[5:0];
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
        imm = ins[15:0];
        a  = mreg[rs];
        b  = mreg[rt];
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0, imm};
        npc = mpc + 32'd4;
        wr = 1'b0; wa = rt; wv = '0;
        e.pc = mpc; e.dout = b; e.addr = '0; e.chk_addr = 1'b1;
        e.memw = (op == 6'h2B);
        e.mio  = (op == 6'h2B) || (op == 6'h23);
        case (op)
            6'h00: begin
                wr = 1'b1; wa = rd;
                case (fn)
                    6'h20: wv = a + b;
                    6'h22: wv = a - b;
                    6'h24: wv = a & b;
                    6'h25: wv = a | b;
                    6'h26: wv = a ^ b;
                    6'h27: wv = ~(a | b);
                    6'h2A: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: wv = b << sh;
                    6'h02: wv = b >> sh;
                    6'h08: begin wr = 1'b0; npc = a; e.chk_addr = 1'b0; end
                    default: begin wr = 1'b0; e.chk_addr = 1'b0; end
                endcase
                e.addr = wv;
            end
            6'h08: begin wr = 1'b1; wv = a + sx; e.addr = wv; end
            6'h0A: begin wr = 1'b1; wv = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; e.addr = wv; end
            6'h0C: begin wr = 1'b1; wv = a & zx; e.addr = wv; end
            6'h0D: begin wr = 1'b1; wv = a | zx; e.addr = wv; end
            6'h0E: begin wr = 1'b1; wv = a ^ zx; e.addr = wv; end
            6'h0F: begin wr = 1'b1; wv = {imm, 16'h0}; e.addr = wv; end
            6'h23: begin wr = 1'b1; wv = din; e.addr = a + sx; end
            6'h2B: begin e.addr = a + sx; end
            6'h04: begin e.chk_addr = 1'b0; if (a == b) npc = mpc + 4 + sx * 4; end
            6'h05: begin e.chk_addr = 1'b0; if (a != b) npc = mpc + 4 + sx * 4; end
            6'h02: begin e.chk_addr = 1'b0; npc = {npc[31:28], ins[25:0], 2'b00}; end
            6'h03: begin
                e.chk_addr = 1'b0;
                wr = 1'b1; wa = 5'd31; wv = mpc + 4;
                npc = {npc[31:28], ins[25:0], 2'b00};
            end
            default: e.chk_addr = 1'b0;
        endcase
        if (wr && wa != 5'd0) mreg[wa] = wv;
        mpc = npc;
    endtask

    // Drive one instruction for one cycle; enters and leaves at posedge+1.
    task automatic issue(input logic [31:0] ins, input logic [31:0] din);
        exp_t e;
        inst_in = ins;
        Data_in = din;
        model_step(ins, din, e);
        e.idx = n_issued;
        n_issued++;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn, op;
        logic [15:0] imm;
        logic [3:0]  off;
        int k;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) rs = 5'd31;
        sh  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        off = 4'($urandom_range(0, 15));
        k = $urandom_range(0, 19);
        if (k <= 7) begin
            case ($urandom_range(0, 8))
                0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                3: fn = 6'h25; 4: fn = 6'h26; 5: fn = 6'h27;
                6: fn = 6'h2A; 7: fn = 6'h00; default: fn = 6'h02;
            endcase
            return {6'h00, rs, rt, rd, sh, fn};
        end else if (k <= 14) begin
            case ($urandom_range(0, 7))
                0: op = 6'h08; 1: op = 6'h0A; 2: op = 6'h0C; 3: op = 6'h0D;
                4: op = 6'h0E; 5: op = 6'h0F; 6: op = 6'h23; default: op = 6'h2B;
            endcase
            return {op, rs, rt, imm};
        end else if (k == 15) begin
            op = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05;
            return {op, rs, rt, {{12{off[3]}}, off}};
        end else if (k == 16) begin
            op = ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03;
            return {op, 26'($urandom)};
        end else if (k == 17) begin
            return {6'h00, rs, 15'd0, 6'h08};
        end else if (k == 18) begin
            case ($urandom_range(0, 2))
                0: op = 6'h01; 1: op = 6'h3F; default: op = 6'h10;
            endcase
            return {op, rs, rt, imm};
        end else begin
            fn = ($urandom_range(0, 1) == 0) ? 6'h01 : 6'h3F;
            return {6'h00, rs, rt, rd, sh, fn};
        end
    endfunction

    // Monitor: compares the next expectation while the DUT presents it.
    always @(negedge clk) begin
        exp_t e;
        if (reset && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("pc", e.idx, PC_out, e.pc);
            chk("data_out", e.idx, Data_out, e.dout);
            chk("mem_w", e.idx, {31'd0, mem_w}, {31'd0, e.memw});
            chk("cpu_mio", e.idx, {31'd0, CPU_MIO}, {31'd0, e.mio});
            if (e.chk_addr) chk("addr_out", e.idx, Addr_out, e.addr);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    logic [31:0] prog [14];
    logic [31:0] post [6];

    initial begin
        reset     = 1'b0;
        inst_in   = '0;
        Data_in   = '0;
        MIO_ready = 1'b1;
        INT       = 1'b0;
        model_reset();

        prog = '{32'h00000000, 32'h00000000, 32'h00000827, 32'h00011020,
                 32'h10000002, 32'h20030005, 32'hAC030008, 32'h8C040000,
                 32'h00802825, 32'h00403025, 32'h08000010, 32'h0C000040,
                 32'h03E00008, 32'h00000000};
        post = '{32'h20000007, 32'h00003825, 32'h1000FFFF, 32'h1000FFFF,
                 32'h20010009, 32'h00210820};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", -1, PC_out, 32'h0);
        chk("rst_addr", -1, Addr_out, 32'h0);
        chk("rst_data_out", -1, Data_out, 32'h0);
        chk("rst_mem_w", -1, {31'd0, mem_w}, 32'd0);
        chk("rst_cpu_mio", -1, {31'd0, CPU_MIO}, 32'd0);

        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            issue(prog[i], (i == 7) ? 32'h1234ABCD : $urandom);
        end

        for (int i = 0; i < 300; i++) issue(rand_inst(), $urandom);

        // Asynchronous reset away from any clock edge.
        reset   = 1'b0;
        inst_in = 32'h0;
        #1;
        chk("midrst_pc", -1, PC_out, 32'h0);
        chk("midrst_data_out", -1, Data_out, 32'h0);
        chk("midrst_addr", -1, Addr_out, 32'h0);
        model_reset();
        #1;
        reset = 1'b1;

        // Read back a previously written register: must be cleared now.
        issue(32'h00403025, $urandom);
        for (int i = 0; i < 6; i++) issue(post[i], $urandom);
        for (int i = 0; i < 150; i++) issue(rand_inst(), $urandom);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scpu_core.md
Name: scpu_core

Overview:
- Single-cycle 32-bit MIPS-subset CPU core: control unit, 32x32 register file, ALU, PC logic.
- Fetches one instruction per clock from external instruction memory (PC_out -> inst_in).
- Accesses external data memory/IO via Addr_out, Data_out, Data_in and mem_w.
- Sits between the instruction ROM and the data RAM/MIO bus in the SoC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Data_in  input  32  read data from data memory/IO, used by lw.
- inst_in  input  32  instruction word at address PC_out.
- MIO_ready  input  1  bus ready; reserved, ignored by this core.
- INT  input  1  interrupt request; reserved, ignored by this core.
- PC_out  output  32  current PC (byte address).
- Addr_out  output  32  ALU result; memory address for lw/sw.
- Data_out  output  32  rt register value; store data for sw.
- mem_w  output  1  1 only while the current instruction is sw.
- CPU_MIO  output  1  1 while the current instruction is lw or sw.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC.
  - All 32 registers cleared to 0.
  - Outputs are combinational from the reset state and inst_in. With inst_in=0: Addr_out=0, Data_out=0, mem_w=0, CPU_MIO=0.
  - Release is sampled at the next rising edge of clk.
- Each cycle is combinational decode/execute. On the rising edge: register write-back and PC update. Latency is 1 cycle per instruction.
- PC update:
  - Default: PC+4.
  - beq/bne taken: PC+4+(signext(imm16)<<2).
  - j/jal: {PC+4[31:28], target26, 2'b00}.
  - jr: rs value.
- Register file:
  - 2 async read ports, 1 sync write port.
  - $0 always reads 0; writes to $0 are discarded.
  - A write and a read of the same register in one cycle returns the old value.
- R-type (op=0), decoded by funct:
  - add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27.
  - slt 0x2A: signed compare, result 1/0.
  - sll 0x00, srl 0x02: shift rt by shamt.
  - jr 0x08.
  - Result goes to rd.
- Arithmetic: add/sub/addi wrap modulo 2^32; no overflow trap.
- I-type, result to rt:
  - addi 0x08, slti 0x0A: signext imm.
  - andi 0x0C, ori 0x0D, xori 0x0E: zeroext imm.
  - lui 0x0F: imm<<16.
  - lw 0x23: rt<=Data_in, addr=rs+signext(imm).
- Other I-type and J-type:
  - sw 0x2B: addr=rs+signext(imm), Data_out=rt, mem_w=1, no register write.
  - beq 0x04, bne 0x05: compare rs and rt.
  - j 0x02.
  - jal 0x03: $31<=PC+4.
- Unknown opcode or funct: behaves as nop (no register write, mem_w=0, PC+4).
- Addr_out is always the ALU result. Data_out is always the rt read value, regardless of opcode.
- Branch to self is legal and holds the PC at that address.

Test Plan:
- Reset: hold reset=0 for 2 cycles, inst_in=0 -> PC_out=0, mem_w=0, Addr_out=0. Release reset -> PC_out steps 0,4,8 on successive edges.
- After reset release: inst_in=0x00000827 (nor $1,$0,$0) -> Addr_out=0xFFFFFFFF that cycle. Next cycle inst_in=0x00011020 (add $2,$0,$1) -> Addr_out=0xFFFFFFFF, and $2=0xFFFFFFFF after the edge.
- addi $3,$0,5 (0x20030005), then sw $3,8($0) (0xAC030008) -> on the sw cycle Addr_out=8, Data_out=5, mem_w=1, CPU_MIO=1.
- lw $4,0($0) (0x8C040000) with Data_in=0x1234ABCD. Then or $5,$4,$0 (0x00802825) -> Addr_out=0x1234ABCD.
- beq $0,$0,+2 (0x10000002) at PC=0x10 -> next PC_out=0x1C. Then j 0x40 (0x08000010) -> next PC_out=0x40.
- jal 0x100 (0x0C000040) at PC=0x40 -> $31=0x44 and PC_out=0x100. Then jr $31 (0x03E00008) -> PC_out=0x44. Asserting reset=0 mid-program -> PC_out=0 immediately, without waiting for a clock edge.
